truth_table_checker: RTL and testbench
======================================

Name: truth_table_checker

Overview:
- Self-running exhaustive checker that sits on the response side of a combinational equation block.
- Sweeps every N_IN-bit input vector into the equation block and holds each vector for a settle window.
- Samples the block's single output `y` and compares it against a parameterised expected truth table.
- Reports the captured truth table, error count, first failing vector and an overall pass/fail verdict.

Parameters:
- N_IN, 3, number of equation inputs; vectors 0..2^N_IN-1 are applied.
- TRUTH, 8'b1001_0110, expected response; bit i is the expected `y` for input vector i; width 2^N_IN.
- SETTLE, 1, cycles each vector is held before sampling; legal range >=1.

Ports:
- clk  in  1  clock, rising-edge active.
- rst_n  in  1  asynchronous reset, active low.
- start  in  1  level-sampled; launches a sweep when the block is in IDLE or DONE.
- vec  out  N_IN  input vector driven to the equation block; MSB maps to equation input A.
- y  in  1  equation block output under test.
- busy  out  1  high while a sweep is in progress.
- done  out  1  high from sweep completion until the next start or reset.
- pass  out  1  valid while done=1; 1 means zero mismatches.
- err_count  out  N_IN+1  number of mismatching vectors in the current or last sweep.
- first_fail  out  N_IN  lowest vector index that mismatched.
- fail_valid  out  1  first_fail holds a valid index.
- resp  out  2^N_IN  captured response; bit i is `y` as sampled for vector i.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - vec, err_count, first_fail and resp are cleared to 0.
  - busy, done, pass and fail_valid are cleared to 0.
  - Reset applied mid-sweep aborts the sweep immediately; no partial verdict is retained.
- FSM states: IDLE, DRIVE, SAMPLE, DONE. All other outputs are registered.
- IDLE or DONE with start=1 at a clock edge:
  - vec<=0, err_count<=0, fail_valid<=0, first_fail<=0, resp<=0, settle counter<=0.
  - busy<=1, done<=0, pass<=0; state goes to DRIVE.
- DRIVE:
  - The settle counter increments each edge.
  - When the counter reaches SETTLE-1, state goes to SAMPLE.
  - vec is stable throughout.
- SAMPLE (one cycle):
  - Capture: resp[vec]<=y.
  - Mismatch (y != TRUTH[vec]): err_count increments. If fail_valid=0, also first_fail<=vec and fail_valid<=1.
  - If vec == 2^N_IN-1: state goes to DONE, busy<=0, done<=1, pass<=(final err_count==0). The final count includes this vector's result.
  - Otherwise: vec<=vec+1, settle counter<=0, state goes to DRIVE.
- Timing:
  - Each vector is held for exactly SETTLE+1 cycles.
  - busy is high for exactly 2^N_IN*(SETTLE+1) cycles.
  - done rises 2^N_IN*(SETTLE+1) edges after the start edge.
- start is ignored while busy=1.
- In DONE, all results hold and vec stays at 2^N_IN-1 until start=1 or reset.
- start held high continuously causes back-to-back sweeps. done pulses high for one cycle between sweeps.
- err_count is sized to reach 2^N_IN with no wrap, so all-vectors-fail is representable.
- `y` is sampled only in SAMPLE; glitches during DRIVE have no effect.

Test Plan:
- XOR3 model, defaults (TRUTH=8'h96, SETTLE=1), start pulse:
  - vec walks 0..7, 2 cycles each.
  - done rises 16 edges after start; pass=1, err_count=0, fail_valid=0, resp=8'h96.
- y stuck at 0, defaults:
  - done after 16 cycles, pass=0, err_count=4.
  - first_fail=1, fail_valid=1, resp=8'h00.
- SETTLE=3, TRUTH=8'hFF, y tied to 1:
  - Each vec is held 4 cycles; busy high for 32 cycles.
  - pass=1, resp=8'hFF.
- Mid-sweep abort and restart, XOR3 model:
  - start pulse while busy at vec=3 → no effect; sweep still ends after 16 cycles.
  - Assert rst_n=0 at vec=5 → all outputs return to 0 immediately, without waiting for clk.
  - Release rst_n, then pulse start → fresh full sweep, pass=1.
- Restart from DONE after a failing run:
  - Run 1 fails with err_count=4.
  - Swap in the correct model and pulse start → counters clear on the start edge; new run gives pass=1, err_count=0.
- start held high with the XOR3 model:
  - Consecutive sweeps run with done high for exactly 1 cycle between them.
  - resp=8'h96 on every sweep.

Source files
------------

// File: rtl/truth_table_checker.sv
// rtl/truth_table_checker.sv - exhaustive truth-table sweep and compare of a single-output equation block
module truth_table_checker #(
  parameter int                      N_IN   = 3,
  parameter logic [(1<<N_IN)-1:0]    TRUTH  = 8'b1001_0110,
  parameter int                      SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [N_IN-1:0]        vec,
  input  logic                   y,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [N_IN:0]          err_count,
  output logic [N_IN-1:0]        first_fail,
  output logic                   fail_valid,
  output logic [(1<<N_IN)-1:0]   resp
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   settle_cnt;
  logic            mismatch;

  assign mismatch = (y != TRUTH[vec]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      vec        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
      fail_valid <= 1'b0;
      resp       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= DRIVE;
            settle_cnt <= '0;
            vec        <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
            fail_valid <= 1'b0;
            resp       <= '0;
          end
        end
        DRIVE: begin
          if (settle_cnt == CW'(SETTLE - 1)) state <= SAMPLE;
          else settle_cnt <= settle_cnt + CW'(1);
        end
        SAMPLE: begin
          resp[vec] <= y;
          if (mismatch) begin
            err_count <= err_count + (N_IN+1)'(1);
            if (!fail_valid) begin
              first_fail <= vec;
              fail_valid <= 1'b1;
            end
          end
          // verdict must fold in the mismatch of the vector being sampled right now
          if (vec == LAST_VEC) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !mismatch;
          end else begin
            vec        <= vec + N_IN'(1);
            settle_cnt <= '0;
            state      <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// tb/tb_truth_table_checker.sv - randomized self-checking bench for truth_table_checker
module tb_truth_table_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] vec0, vec1, ff0, ff1;
  logic       y0, y1, busy0, busy1, done0, done1, pass0, pass1, fv0, fv1;
  logic [3:0] err0, err1;
  logic [7:0] resp0, resp1;

  logic [7:0] tbl0 = 8'h96;
  logic [7:0] tbl1 = 8'hFF;
  logic       gl0 = 1'b0, gl1 = 1'b0, glen = 1'b0, chk_en = 1'b0;

  assign y0 = tbl0[vec0] ^ gl0;
  assign y1 = tbl1[vec1] ^ gl1;

  truth_table_checker #(.N_IN(3), .TRUTH(8'h96), .SETTLE(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .vec(vec0), .y(y0), .busy(busy0),
    .done(done0), .pass(pass0), .err_count(err0), .first_fail(ff0),
    .fail_valid(fv0), .resp(resp0));

  truth_table_checker #(.N_IN(3), .TRUTH(8'hFF), .SETTLE(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .vec(vec1), .y(y1), .busy(busy1),
    .done(done1), .pass(pass1), .err_count(err1), .first_fail(ff1),
    .fail_valid(fv1), .resp(resp1));

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int s_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [7:0] truth_of(input int i);
    return (i == 0) ? 8'h96 : 8'hFF;
  endfunction

  // Model: a sweep is just "c cycles since the start edge"; everything follows from c
  int         m_c    [2];
  bit         m_run  [2];
  bit         m_done [2];
  logic [7:0] m_tbl  [2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_run[i] <= 0; m_done[i] <= 0; m_c[i] <= 0;
      end else if (m_run[i]) begin
        m_c[i] <= m_c[i] + 1;
        if (m_c[i] + 1 == 8 * (s_of(i) + 1)) begin
          m_run[i] <= 0; m_done[i] <= 1;
        end
      end else if (start) begin
        m_run[i] <= 1; m_done[i] <= 0; m_c[i] <= 0;
        m_tbl[i] <= (i == 0) ? tbl0 : tbl1;
      end
    end
  end

  function automatic void model_out(input int s, input logic [7:0] truth, input logic [7:0] t,
                                    input int c, input bit dn, output int ev, output int ee,
                                    output int eff, output int efv, output int eresp);
    int k;
    k     = dn ? 8 : c / (s + 1);
    ev    = dn ? 7 : c / (s + 1);
    ee    = 0; eff = 0; efv = 0; eresp = 0;
    for (int v = 0; v < k; v++) begin
      if (t[v] != truth[v]) begin
        ee++;
        if (efv == 0) begin eff = v; efv = 1; end
      end
      if (t[v]) eresp = eresp | (1 << v);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        int ev, ee, eff, efv, eresp;
        model_out(s_of(i), truth_of(i), m_tbl[i], m_c[i], m_done[i], ev, ee, eff, efv, eresp);
        chk($sformatf("vec%0d", i),   (i == 0) ? vec0  : vec1,  ev);
        chk($sformatf("busy%0d", i),  (i == 0) ? busy0 : busy1, int'(m_run[i]));
        chk($sformatf("done%0d", i),  (i == 0) ? done0 : done1, int'(m_done[i]));
        chk($sformatf("pass%0d", i),  (i == 0) ? pass0 : pass1, int'(m_done[i] && ee == 0));
        chk($sformatf("err%0d", i),   (i == 0) ? err0  : err1,  ee);
        chk($sformatf("ff%0d", i),    (i == 0) ? ff0   : ff1,   eff);
        chk($sformatf("fv%0d", i),    (i == 0) ? fv0   : fv1,   efv);
        chk($sformatf("resp%0d", i),  (i == 0) ? resp0 : resp1, eresp);
      end
    end
  end

  // y glitches only in settle cycles of a sweep; it is clean in every sample cycle
  always @(posedge clk) begin
    #3;
    gl0 = (glen && m_run[0] && (m_c[0] % 2) != 1) ? 1'($urandom % 2) : 1'b0;
    gl1 = (glen && m_run[1] && (m_c[1] % 4) != 3) ? 1'($urandom % 2) : 1'b0;
  end

  task automatic sweep(output int e0, output int e1, output int err_at_start);
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    err_at_start = err0;
    e0 = 0; e1 = 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done0 && e0 == 0) e0 = n;
      if (done1 && e1 == 0) e1 = n;
      if (e0 != 0 && e1 != 0) break;
    end
  endtask

  initial begin
    int e0, e1, es, n, pulses;
    bit pulsed, prev_done;
    #1 rst_n = 1'b0;
    #2;
    chk_en = 1'b1;
    chk("rst_vec", vec0, 0);   chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0); chk("rst_resp", resp0, 0);
    @(posedge clk); #2 rst_n = 1'b1;

    sweep(e0, e1, es);
    chk("xor_done_edge", e0, 16);  chk("s3_done_edge", e1, 32);
    chk("xor_pass", pass0, 1);     chk("xor_err", err0, 0);
    chk("xor_fv", fv0, 0);         chk("xor_resp", resp0, 8'h96);
    chk("s3_pass", pass1, 1);      chk("s3_resp", resp1, 8'hFF);

    tbl0 = 8'h00;
    sweep(e0, e1, es);
    chk("stuck_done_edge", e0, 16); chk("stuck_pass", pass0, 0);
    chk("stuck_err", err0, 4);      chk("stuck_ff", ff0, 1);
    chk("stuck_fv", fv0, 1);        chk("stuck_resp", resp0, 8'h00);

    tbl0 = 8'h96;
    sweep(e0, e1, es);
    chk("restart_err_clear", es, 0);
    chk("restart_pass", pass0, 1);  chk("restart_err", err0, 0);

    // start while busy is ignored
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    pulsed = 0; n = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done0) begin n = k; break; end
      if (vec0 == 3'd3 && !pulsed) begin #1 start = 1'b1; pulsed = 1; end
    end
    chk("busy_start_ignored", n, 16);
    for (int k = 0; k < 40 && busy1; k++) @(posedge clk);

    // asynchronous abort mid-sweep
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    for (int k = 0; k < 100 && vec0 != 3'd5; k++) begin @(posedge clk); #1; end
    #1 rst_n = 1'b0;
    #1;
    chk("abort_vec", vec0, 0);   chk("abort_busy", busy0, 0);
    chk("abort_err", err0, 0);   chk("abort_resp", resp0, 0);
    chk("abort_done", done0, 0); chk("abort_busy1", busy1, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    sweep(e0, e1, es);
    chk("post_abort_edge", e0, 16); chk("post_abort_pass", pass0, 1);

    // random response tables with settle-window glitches
    glen = 1'b1;
    for (int r = 0; r < 6; r++) begin
      tbl0 = 8'($urandom);
      tbl1 = 8'($urandom);
      if (r == 0) tbl0 = 8'h69;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      sweep(e0, e1, es);
      chk("rand_done_edge", e0, 16);
      chk("rand_done_edge1", e1, 32);
      if (r == 0) begin
        chk("all_fail_err", err0, 8);
        chk("all_fail_ff", ff0, 0);
      end
    end

    // start held high: back-to-back sweeps
    tbl0 = 8'h96; tbl1 = 8'hFF;
    @(posedge clk); #2 start = 1'b1;
    pulses = 0; prev_done = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (done0) begin
        pulses++;
        chk("held_done_width", int'(prev_done), 0);
        chk("held_resp", resp0, 8'h96);
      end
      prev_done = done0;
    end
    start = 1'b0;
    chk("held_pulses", pulses, 3);
    for (int k = 0; k < 80 && (busy0 || busy1); k++) @(posedge clk);
    @(posedge clk); #2;
    chk("held_idle", int'(busy0 || busy1), 0);

    @(posedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
